bus_datapath_memseq: RTL
========================

BUS_DATAPATH_MEMSEQ -- requirements
Module: bus_datapath_memseq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bus, register and memory data width.
REQ-002 SHALL have parameter NREGS, default 16, range 2..32: general-purpose register count.
REQ-003 SHALL have parameter ADDR_W, default 9: MAR and memory address width.
REQ-004 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for mem_ack (used only under REQ-030).
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port clr, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port src_sel, input, SW=$clog2(NREGS+2): bus source. Codes: 0..NREGS-1 = register; NREGS = MDR; NREGS+1 = ext_in.
REQ-008 SHALL have port dst_we, input, NREGS: per-register load-from-bus enables.
REQ-009 SHALL have port ba_out, input, 1: when high, register 0 reads as zero on the bus.
REQ-010 SHALL have port ext_in, input, WIDTH: external (inport) data.
REQ-011 SHALL have ports mar_we and mdr_we, input, 1 each: load MAR (low ADDR_W bits of bus) or MDR from the bus.
REQ-012 SHALL have ports op_start and op_write, input, 1 each: start a memory transfer; op_write=1 means write, 0 means read.
REQ-013 SHALL have ports busy, done and err, output, 1 each: transfer status.
REQ-014 SHALL have ports mem_req and mem_we, output, 1 each; mem_addr, output, ADDR_W; mem_wdata, output, WIDTH.
REQ-015 SHALL have ports mem_rdata, input, WIDTH, and mem_ack, input, 1.
REQ-016 SHALL have port bus, output, WIDTH: current bus value.

Function
REQ-017 bus SHALL be combinational from src_sel. Register 0 SHALL read as 0 when ba_out=1. Codes >= NREGS+2 SHALL drive 0.
REQ-018 Every register whose dst_we bit is high SHALL load bus at the clock edge. Multiple bits may be high; each selected register loads the same value.
REQ-019 A register with dst_we high and selected as source SHALL load its own old value, with no combinational loop.
REQ-020 The sequencer FSM SHALL have states IDLE, ACCESS and DONE; busy SHALL be 1 in ACCESS and DONE.
REQ-021 IDLE to ACCESS on op_start=1. At that edge the block SHALL latch op_write, MAR and MDR into the transfer registers.
REQ-022 In ACCESS: mem_req=1, mem_we equals the latched op_write, mem_addr and mem_wdata equal the latched values; all four SHALL hold stable until mem_ack.
REQ-023 ACCESS with mem_ack=1 SHALL go to DONE. For a read, MDR SHALL load mem_rdata at that edge.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE. Minimum transfer is 3 cycles from op_start to IDLE.
REQ-025 While busy=1, op_start, mar_we and mdr_we SHALL be ignored. Register and dst_we traffic continues normally.
REQ-026 In IDLE, simultaneous op_start and mar_we/mdr_we SHALL latch the pre-edge MAR/MDR. The MAR/MDR update still happens.
REQ-027 mem_ack outside ACCESS SHALL be ignored. Outside ACCESS, mem_req and mem_we SHALL be 0.

Reset
REQ-028 When clr=1 at a clock edge, all registers, MAR, MDR, transfer latches and err SHALL become 0, and the FSM SHALL go to IDLE. This holds mid-transfer; the pending mem_ack is then dropped.
REQ-029 clr SHALL override every enable in the same cycle. After reset, busy, done, err, mem_req and mem_we SHALL all be 0.

Configuration
REQ-030 With macro BUS_DATAPATH_MEM_TIMEOUT_EN defined, a wait counter SHALL run in ACCESS. If TIMEOUT cycles pass without mem_ack, the block SHALL:
- go to DONE;
- set err=1 and hold it until the next op_start or clr;
- leave MDR unchanged.
REQ-031 Without the macro, ACCESS SHALL wait indefinitely and err SHALL be tied to 0.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (IDLE, ACCESS, DONE) and the src_sel codes SRC_MDR and SRC_EXT as functions of NREGS.
REQ-033 The FSM, transfer latches and timeout counter SHALL be one sub-module, mem_xfer_fsm. The register file and bus mux stay in the top module.

Verification
REQ-034 Reset, then ext_in=32'hDEAD_BEEF, src_sel=SRC_EXT, dst_we[3]=1 -> R3=DEADBEEF; then src_sel=3 shows DEADBEEF on bus.
REQ-035 R0=5, ba_out=1, src_sel=0 -> bus=0; with ba_out=0 -> bus=5.
REQ-036 MAR=9'h1A, MDR=32'h1234, op_write=1, op_start pulse, mem_ack after 4 cycles -> mem_req high 4 cycles with addr 1A and wdata 1234, then done pulses once, then IDLE.
REQ-037 Read at MAR=9'h05 with mem_rdata=32'hCAFE and ack on the 2nd ACCESS cycle -> MDR=CAFE; mdr_we pulses during busy leave MDR unaffected.
REQ-038 clr asserted during ACCESS -> next cycle all outputs 0 and state IDLE; a late mem_ack is ignored.
REQ-039 With the macro defined, TIMEOUT=15 and no ack -> after 15 ACCESS cycles, done=1, err=1, MDR unchanged; the next op_start clears err.

Source files
------------

// File: rtl/bus_datapath_memseq_pkg.sv
// Shared definitions for the bus datapath / memory sequencer slice:
// transfer FSM state encoding and the non-register bus source codes.
package bus_datapath_memseq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } xfer_state_e;

   // Bus source code that selects the MDR; registers occupy 0..nregs-1.
   function automatic int SRC_MDR(input int nregs);
      return nregs;
   endfunction

   // Bus source code that selects the external inport.
   function automatic int SRC_EXT(input int nregs);
      return nregs + 1;
   endfunction

endpackage

// File: rtl/bus_datapath_memseq_mem_xfer_fsm.sv
// Memory transfer sequencer: IDLE -> ACCESS -> DONE -> IDLE.
// Latches direction, address and write data when a transfer is accepted and
// holds them on the memory port for the whole access.
// Optional feature macro: BUS_DATAPATH_MEM_TIMEOUT_EN adds an ACCESS wait
// counter that abandons the transfer after TIMEOUT cycles and raises err.
module mem_xfer_fsm
   import bus_datapath_memseq_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              op_start_i,
   input  logic              op_write_i,
   input  logic [ADDR_W-1:0] mar_i,
   input  logic [WIDTH-1:0]  mdr_i,
   input  logic              mem_ack_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [WIDTH-1:0]  mem_wdata_o,
   output logic              rd_load_o
);

   xfer_state_e       state_q, state_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  wdata_q;
   logic              accept;
   logic              tmo_hit;

   // State register; clr returns to IDLE even mid-transfer.
   always_ff @(posedge clk) begin
      if (clr) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and status decode.
   always_comb begin
      state_d   = state_q;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      rd_load_o = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (op_start_i) begin
               state_d = ACCESS;
               accept  = 1'b1;
            end
         end
         ACCESS: begin
            busy_o    = 1'b1;
            mem_req_o = 1'b1;
            mem_we_o  = we_q;
            if (mem_ack_i) begin
               state_d   = DONE;
               rd_load_o = ~we_q;
            end else if (tmo_hit) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Transfer latches capture the pre-edge MAR/MDR when a transfer starts.
   always_ff @(posedge clk) begin
      if (clr) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= op_write_i;
         addr_q  <= mar_i;
         wdata_q <= mdr_i;
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;

`ifdef BUS_DATAPATH_MEM_TIMEOUT_EN
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   logic [WAIT_W-1:0] wait_q;
   logic              err_q;

   // The last permitted ACCESS cycle without an ack forces the exit.
   assign tmo_hit = (state_q == ACCESS) && !mem_ack_i &&
                    (wait_q == WAIT_W'(TIMEOUT - 1));

   // Count cycles spent in ACCESS; restart from zero on every entry.
   always_ff @(posedge clk) begin
      if (clr)                    wait_q <= '0;
      else if (state_q == ACCESS) wait_q <= wait_q + 1'b1;
      else                        wait_q <= '0;
   end

   // Sticky error: set on timeout, cleared by the next accepted start.
   always_ff @(posedge clk) begin
      if (clr)          err_q <= 1'b0;
      else if (accept)  err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   logic [31:0] timeout_unused;

   assign timeout_unused = TIMEOUT;
   assign tmo_hit        = 1'b0;
   assign err_o          = 1'b0;
`endif

endmodule

// File: rtl/bus_datapath_memseq.sv
// Single-bus datapath: register file, MAR/MDR and a memory transfer
// sequencer (mem_xfer_fsm). The bus is a combinational mux over registers,
// MDR and the external inport.
// Optional feature macro: BUS_DATAPATH_MEM_TIMEOUT_EN (ACCESS timeout, err).
module bus_datapath_memseq
   import bus_datapath_memseq_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int NREGS   = 16,
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 15
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic [$clog2(NREGS+2)-1:0] src_sel,
   input  logic [NREGS-1:0]           dst_we,
   input  logic                       ba_out,
   input  logic [WIDTH-1:0]           ext_in,
   input  logic                       mar_we,
   input  logic                       mdr_we,
   input  logic                       op_start,
   input  logic                       op_write,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic                       mem_req,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [WIDTH-1:0]           mem_wdata,
   input  logic [WIDTH-1:0]           mem_rdata,
   input  logic                       mem_ack,
   output logic [WIDTH-1:0]           bus
);

   localparam int            SW      = $clog2(NREGS + 2);
   localparam logic [SW-1:0] SEL_MDR = SW'(SRC_MDR(NREGS));
   localparam logic [SW-1:0] SEL_EXT = SW'(SRC_EXT(NREGS));

   logic [WIDTH-1:0]  regs_q [NREGS];
   logic [ADDR_W-1:0] mar_q;
   logic [WIDTH-1:0]  mdr_q;
   logic [WIDTH-1:0]  bus_mux;
   logic              xfer_busy;
   logic              rd_load;

   // Bus source mux; unused codes drive zero, ba_out masks register 0.
   always_comb begin
      bus_mux = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (src_sel == SW'(i)) begin
            bus_mux = (i == 0 && ba_out) ? '0 : regs_q[i];
         end
      end
      if (src_sel == SEL_MDR) bus_mux = mdr_q;
      if (src_sel == SEL_EXT) bus_mux = ext_in;
   end

   assign bus = bus_mux;

   // Register file: every enabled register loads the same bus value.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (dst_we[i]) regs_q[i] <= bus_mux;
         end
      end
   end

   // MAR/MDR: bus loads are frozen while a transfer is in flight; a read
   // completion is the only writer of MDR during that time.
   always_ff @(posedge clk) begin
      if (clr) begin
         mar_q <= '0;
         mdr_q <= '0;
      end else begin
         if (mar_we && !xfer_busy) mar_q <= bus_mux[ADDR_W-1:0];
         if (rd_load)                   mdr_q <= mem_rdata;
         else if (mdr_we && !xfer_busy) mdr_q <= bus_mux;
      end
   end

   mem_xfer_fsm #(
      .WIDTH   (WIDTH),
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) u_xfer (
      .clk         (clk),
      .clr         (clr),
      .op_start_i  (op_start),
      .op_write_i  (op_write),
      .mar_i       (mar_q),
      .mdr_i       (mdr_q),
      .mem_ack_i   (mem_ack),
      .busy_o      (xfer_busy),
      .done_o      (done),
      .err_o       (err),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .rd_load_o   (rd_load)
   );

   assign busy = xfer_busy;

endmodule
